// File: rtl/td4_core_if.sv
// Bus bundle between the TD4 core and its environment: execute enable, ROM
// instruction/address pair, I/O ports and the architectural state taps.
interface td4_core_if #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
);
    logic              en;
    logic [DATA_W+3:0] instr;
    logic [DATA_W-1:0] in_port;
    logic [PC_W-1:0]   pc;
    logic [DATA_W-1:0] out_port;
    logic              carry;
    logic              halt;
    logic [DATA_W-1:0] reg_a;
    logic [DATA_W-1:0] reg_b;

    modport master (
        output en, instr, in_port,
        input  pc, out_port, carry, halt, reg_a, reg_b
    );

    modport slave (
        input  en, instr, in_port,
        output pc, out_port, carry, halt, reg_a, reg_b
    );
endinterface

// File: rtl/td4_core.sv
// TD4-style 4-bit-class CPU core: two registers, carry flag, registered output
// port, single-cycle execution of the instruction presented at pc.
module td4_core #(
    parameter int DATA_W = 4,
    parameter int PC_W   = 4
) (
    input logic       clk,
    input logic       reset,
    td4_core_if.slave bus
);
    typedef enum logic [3:0] {
        OP_ADD_A  = 4'b0000,
        OP_MOV_AB = 4'b0001,
        OP_IN_A   = 4'b0010,
        OP_MOV_A  = 4'b0011,
        OP_MOV_BA = 4'b0100,
        OP_ADD_B  = 4'b0101,
        OP_IN_B   = 4'b0110,
        OP_MOV_B  = 4'b0111,
        OP_OUT_B  = 4'b1001,
        OP_OUT_I  = 4'b1011,
        OP_JNC    = 4'b1110,
        OP_JMP    = 4'b1111
    } op_e;

    function automatic logic [DATA_W:0] alu_add(input logic [DATA_W-1:0] src,
                                                input logic [DATA_W-1:0] im);
        return {1'b0, src} + {1'b0, im};
    endfunction

    // Jump targets come from the immediate field, which may be wider or
    // narrower than the program counter.
    function automatic logic [PC_W-1:0] fit_pc(input logic [DATA_W-1:0] v);
        logic [PC_W+DATA_W-1:0] ext;
        ext = {{PC_W{1'b0}}, v};
        return ext[PC_W-1:0];
    endfunction

    logic [PC_W-1:0]   r_pc;
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [DATA_W-1:0] r_out;
    logic              r_carry;
    logic              r_halt;

    logic [3:0]        w_op;
    logic [DATA_W-1:0] w_im;
    logic [DATA_W-1:0] w_src;
    logic [DATA_W:0]   w_sum;
    logic [PC_W-1:0]   w_pc_inc;
    logic [PC_W-1:0]   w_target;

    logic [PC_W-1:0]   w_pc_nxt;
    logic [DATA_W-1:0] w_a_nxt;
    logic [DATA_W-1:0] w_b_nxt;
    logic [DATA_W-1:0] w_out_nxt;
    logic              w_carry_nxt;
    logic              w_halt_nxt;

    assign w_op     = bus.instr[DATA_W+3:DATA_W];
    assign w_im     = bus.instr[DATA_W-1:0];
    assign w_src    = (w_op == OP_ADD_B) ? r_b : r_a;
    assign w_sum    = alu_add(w_src, w_im);
    assign w_pc_inc = r_pc + PC_W'(1);
    assign w_target = fit_pc(w_im);

    // Instruction decode: every defined opcode except ADD clears carry;
    // undefined opcodes fall through to the defaults and only advance pc.
    always_comb begin
        w_pc_nxt    = w_pc_inc;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_out_nxt   = r_out;
        w_carry_nxt = r_carry;
        w_halt_nxt  = r_halt;
        case (w_op)
            OP_ADD_A: begin
                w_a_nxt     = w_sum[DATA_W-1:0];
                w_carry_nxt = w_sum[DATA_W];
            end
            OP_ADD_B: begin
                w_b_nxt     = w_sum[DATA_W-1:0];
                w_carry_nxt = w_sum[DATA_W];
            end
            OP_MOV_A: begin
                w_a_nxt     = w_im;
                w_carry_nxt = 1'b0;
            end
            OP_MOV_B: begin
                w_b_nxt     = w_im;
                w_carry_nxt = 1'b0;
            end
            OP_MOV_AB: begin
                w_a_nxt     = r_b;
                w_carry_nxt = 1'b0;
            end
            OP_MOV_BA: begin
                w_b_nxt     = r_a;
                w_carry_nxt = 1'b0;
            end
            OP_IN_A: begin
                w_a_nxt     = bus.in_port;
                w_carry_nxt = 1'b0;
            end
            OP_IN_B: begin
                w_b_nxt     = bus.in_port;
                w_carry_nxt = 1'b0;
            end
            OP_OUT_B: begin
                w_out_nxt   = r_b;
                w_carry_nxt = 1'b0;
            end
            OP_OUT_I: begin
                w_out_nxt   = w_im;
                w_carry_nxt = 1'b0;
            end
            OP_JMP: begin
                w_pc_nxt    = w_target;
                w_carry_nxt = 1'b0;
                // A self-jump is the program's way of stopping; flag is sticky.
                if (w_target == r_pc) w_halt_nxt = 1'b1;
            end
            OP_JNC: begin
                if (!r_carry) w_pc_nxt = w_target;
                w_carry_nxt = 1'b0;
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_out   <= '0;
            r_carry <= 1'b0;
            r_halt  <= 1'b0;
        end else if (bus.en) begin
            r_pc    <= w_pc_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_out   <= w_out_nxt;
            r_carry <= w_carry_nxt;
            r_halt  <= w_halt_nxt;
        end
    end

    assign bus.pc       = r_pc;
    assign bus.reg_a    = r_a;
    assign bus.reg_b    = r_b;
    assign bus.out_port = r_out;
    assign bus.carry    = r_carry;
    assign bus.halt     = r_halt;
endmodule

// File: tb/tb_td4_core.sv
// Directed-program bench for td4_core: a small ROM feeds instr from pc; the
// expected architectural state after every edge goes to a scoreboard queue.
module tb_td4_core;
    logic clk = 1'b0;
    logic rst = 1'b1;

    td4_core_if #(.DATA_W(4), .PC_W(4)) bus ();

    td4_core #(.DATA_W(4), .PC_W(4)) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    logic [7:0] rom [16];
    assign bus.instr = rom[bus.pc];

    typedef struct {
        string      name;
        logic [3:0] pc;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] o;
        logic       c;
        logic       h;
    } exp_t;

    exp_t sb [$];
    exp_t mon_x;
    int   n_checks = 0;
    int   n_fails  = 0;

    function automatic exp_t mk(input string nm, input logic [3:0] pc,
                                input logic [3:0] a, input logic [3:0] b,
                                input logic [3:0] o, input logic c, input logic h);
        exp_t x;
        x.name = nm; x.pc = pc; x.a = a; x.b = b; x.o = o; x.c = c; x.h = h;
        return x;
    endfunction

    function automatic logic [7:0] ins(input logic [3:0] op, input logic [3:0] im);
        return {op, im};
    endfunction

    function automatic void chk(input string nm, input string fld,
                                input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endfunction

    // Monitor: every edge yields one architectural state snapshot.
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            mon_x = sb.pop_front();
            chk(mon_x.name, "pc",    bus.pc,              mon_x.pc);
            chk(mon_x.name, "reg_a", bus.reg_a,           mon_x.a);
            chk(mon_x.name, "reg_b", bus.reg_b,           mon_x.b);
            chk(mon_x.name, "out",   bus.out_port,        mon_x.o);
            chk(mon_x.name, "carry", {3'b000, bus.carry}, {3'b000, mon_x.c});
            chk(mon_x.name, "halt",  {3'b000, bus.halt},  {3'b000, mon_x.h});
        end
    end

    task automatic cyc(input logic e, input logic r, input exp_t x);
        bus.en = e;
        rst    = r;
        @(posedge clk);
        #1;
        sb.push_back(x);
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 16; i++) rom[i] = ins(4'b1000, 4'h0);
    endtask

    initial begin
        bus.en      = 1'b1;
        bus.in_port = 4'h0;
        clear_rom();

        // Reset overrides en and instr for two edges
        rom[0] = ins(4'b0011, 4'h5);
        cyc(1, 1, mk("rst0", 0, 0, 0, 0, 0, 0));
        cyc(1, 1, mk("rst1", 0, 0, 0, 0, 0, 0));

        // Carry out of ADD, JNC not taken, NOP keeps carry, MOV clears it
        clear_rom();
        rom[0] = ins(4'b0011, 4'h8);
        rom[1] = ins(4'b0000, 4'h9);
        rom[2] = ins(4'b1110, 4'h0);
        rom[3] = ins(4'b0000, 4'hF);
        rom[4] = ins(4'b1010, 4'h7);
        rom[5] = ins(4'b0001, 4'h0);
        cyc(1, 1, mk("c_rst",  0, 0, 0, 0, 0, 0));
        cyc(1, 0, mk("c_mov",  1, 8, 0, 0, 0, 0));
        cyc(1, 0, mk("c_add",  2, 1, 0, 0, 1, 0));
        cyc(1, 0, mk("c_jnc",  3, 1, 0, 0, 0, 0));
        cyc(1, 0, mk("c_add2", 4, 0, 0, 0, 1, 0));
        cyc(1, 0, mk("c_nop",  5, 0, 0, 0, 1, 0));
        cyc(1, 0, mk("c_movab",6, 0, 0, 0, 0, 0));

        // JNC taken
        clear_rom();
        rom[0] = ins(4'b0111, 4'h2);
        rom[1] = ins(4'b0101, 4'h3);
        rom[2] = ins(4'b1110, 4'hC);
        cyc(1, 1, mk("j_rst",  0,  0, 0, 0, 0, 0));
        cyc(1, 0, mk("j_movb", 1,  0, 2, 0, 0, 0));
        cyc(1, 0, mk("j_addb", 2,  0, 5, 0, 0, 0));
        cyc(1, 0, mk("j_jnc",  12, 0, 5, 0, 0, 0));
        cyc(1, 0, mk("j_nop",  13, 0, 5, 0, 0, 0));

        // I/O path
        clear_rom();
        rom[0] = ins(4'b0010, 4'h0);
        rom[1] = ins(4'b0100, 4'h0);
        rom[2] = ins(4'b1001, 4'h0);
        rom[3] = ins(4'b1011, 4'hA);
        rom[4] = ins(4'b0110, 4'h0);
        bus.in_port = 4'h6;
        cyc(1, 1, mk("io_rst",  0, 0, 0, 0,  0, 0));
        cyc(1, 0, mk("io_ina",  1, 6, 0, 0,  0, 0));
        cyc(1, 0, mk("io_movba",2, 6, 6, 0,  0, 0));
        cyc(1, 0, mk("io_outb", 3, 6, 6, 6,  0, 0));
        cyc(1, 0, mk("io_outi", 4, 6, 6, 10, 0, 0));
        bus.in_port = 4'h3;
        cyc(1, 0, mk("io_inb",  5, 6, 3, 10, 0, 0));

        // Stall at pc=15, then wrap
        clear_rom();
        rom[0]  = ins(4'b0011, 4'h3);
        rom[1]  = ins(4'b1111, 4'hF);
        rom[15] = ins(4'b0000, 4'h1);
        cyc(1, 1, mk("s_rst",  0,  0, 0, 0, 0, 0));
        cyc(1, 0, mk("s_mov",  1,  3, 0, 0, 0, 0));
        cyc(1, 0, mk("s_jmp",  15, 3, 0, 0, 0, 0));
        bus.in_port = 4'hF;
        cyc(0, 0, mk("s_st0",  15, 3, 0, 0, 0, 0));
        cyc(0, 0, mk("s_st1",  15, 3, 0, 0, 0, 0));
        cyc(0, 0, mk("s_st2",  15, 3, 0, 0, 0, 0));
        cyc(1, 0, mk("s_wrap", 0,  4, 0, 0, 0, 0));
        cyc(1, 0, mk("s_mov2", 1,  3, 0, 0, 0, 0));

        // Halt on self-jump, sticky through stall, cleared by reset mid-program
        clear_rom();
        rom[0] = ins(4'b1111, 4'h7);
        rom[7] = ins(4'b1111, 4'h7);
        cyc(1, 1, mk("h_rst",  0, 0, 0, 0, 0, 0));
        cyc(1, 0, mk("h_jmp",  7, 0, 0, 0, 0, 0));
        cyc(1, 0, mk("h_self", 7, 0, 0, 0, 0, 1));
        cyc(1, 0, mk("h_hold", 7, 0, 0, 0, 0, 1));
        cyc(0, 0, mk("h_stall",7, 0, 0, 0, 0, 1));
        cyc(1, 1, mk("h_rst2", 0, 0, 0, 0, 0, 0));
        cyc(1, 0, mk("h_again",7, 0, 0, 0, 0, 0));

        bus.en = 1'b0;
        for (int i = 0; i < 4 && sb.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (sb.size() != 0) begin
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule

// File: doc/td4_core.md
TD4_CORE -- requirements
Module: td4_core

Interface
REQ-001 Parameter DATA_W, default 4: register, immediate, ALU and I/O port width; legal range 4..16.
REQ-002 Parameter PC_W, default 4: program counter width; legal range 4..12.
REQ-003 Port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Port en  input  1: execute enable; 1 = execute the current instruction this cycle, 0 = stall.
REQ-006 Port instr  input  4+DATA_W: instruction word, opcode = instr[DATA_W+3:DATA_W], im = instr[DATA_W-1:0], driven combinationally by external ROM from pc.
REQ-007 Port in_port  input  DATA_W: external input data.
REQ-008 Port pc  output  PC_W: program counter, ROM address.
REQ-009 Port out_port  output  DATA_W: registered output port.
REQ-010 Port carry  output  1: carry flag.
REQ-011 Port halt  output  1: self-jump detected flag.
REQ-012 Port reg_a, reg_b  output  DATA_W each: register A and B contents, for debug.

Function
REQ-013 Execution SHALL be single-cycle: when en=1, the instruction at pc SHALL complete at the next rising edge; no other latency.
REQ-014 ALU SHALL compute sum = src + im at DATA_W+1 bits; result = low DATA_W bits; cout = bit DATA_W.
REQ-015 Opcode 0000 ADD A,im: A <= A+im, carry <= cout.
REQ-016 Opcode 0101 ADD B,im: B <= B+im, carry <= cout.
REQ-017 Opcodes 0011 MOV A,im / 0111 MOV B,im: destination <= im.
REQ-018 Opcodes 0001 MOV A,B / 0100 MOV B,A: destination <= source.
REQ-019 Opcodes 0010 IN A / 0110 IN B: destination <= in_port sampled at the executing edge.
REQ-020 Opcodes 1001 OUT B / 1011 OUT im: out_port <= B or im respectively.
REQ-021 Opcode 1111 JMP im: pc <= im zero-extended or truncated to PC_W.
REQ-022 Opcode 1110 JNC im: if carry=0 before the edge, pc <= im (as REQ-021); else pc <= pc+1.
REQ-023 Every defined opcode other than ADD SHALL clear carry to 0 when executed.
REQ-024 Undefined opcodes SHALL execute as NOP: pc <= pc+1; A, B, out_port, carry unchanged.
REQ-025 All non-jump instructions, and JNC not taken, SHALL set pc <= pc+1 modulo 2^PC_W (max wraps to 0).
REQ-026 halt SHALL set to 1 at the edge executing JMP whose target equals current pc, and SHALL stay 1 until reset; it does not gate execution.
REQ-027 en=0 SHALL hold pc, A, B, out_port, carry, halt unchanged regardless of instr and in_port.
REQ-028 Registers not written by an instruction SHALL keep their value.

Reset
REQ-029 reset=1 at a rising edge SHALL force pc=0, A=0, B=0, out_port=0, carry=0, halt=0, overriding en and instr.
REQ-030 Reset asserted mid-program SHALL discard the current instruction; first instruction after release executes from pc=0.
REQ-031 Without reset, outputs are undefined; no state SHALL depend on power-up value after first reset edge.

Verification (DATA_W=4, PC_W=4)
REQ-032 Reset: reset=1 for 2 edges with en=1, instr=MOV A,5 -> pc=0, reg_a=0, out_port=0, carry=0, halt=0.
REQ-033 Carry: MOV A,8; ADD A,9; JNC 0 -> reg_a=1, carry=1 after ADD; JNC not taken, pc=3, carry=0.
REQ-034 JNC taken: MOV B,2; ADD B,3; JNC 12 -> reg_b=5, carry=0, pc=12.
REQ-035 I/O: in_port=6; IN A; MOV B,A; OUT B; OUT 10 -> out_port=6 then 10; reg_b=6.
REQ-036 Stall and wrap: en=0 for 3 cycles at pc=15 with ADD A,1 -> no state change; en=1 -> pc=0, reg_a incremented by 1.
REQ-037 Halt: JMP 7 placed at address 7 -> halt=1, pc stays 7 each cycle; reset -> halt=0, pc=0.
